vga_capture: RTL and testbench

- Receive-side counterpart of the VGA output path: samples the H_SYNC/V_SYNC/RGB stream that the renderer drives to the pins.
- Locks to 640x480 timing and recovers pixel coordinates and colour.
- Provides frame counting, a single-pixel probe and sticky timing-error flags.
- Used as an on-chip loopback monitor and as the bench-side checker for the display path.

---
 rtl/vga_capture.sv | 272 +++++++++++++++++++++++++++
 tb/tb_vga_capture.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// -----------------------------------------------------------------------------
// vga_capture
//   Receive-side VGA timing monitor. Samples h_sync/v_sync/RGB on pix_ce
//   strobes, locks to the configured timing, recovers pixel coordinates and
//   colour, counts locked frames, captures one probed pixel and keeps sticky
//   line/frame length error flags.
//
//   Optional feature macro: VGA_CAPTURE_CRC_EN
//     defined   : per-frame CRC-16-CCITT over the recovered pixels
//     undefined : frame_crc / crc_valid tied to 0, no CRC logic
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   pix_ce               pixel strobe, all sampling gated by it
//   h_sync, v_sync       sync inputs (polarity from SYNC_ACTIVE)
//   red, green, blue     4-bit colour inputs
//   probe_x, probe_y     probe coordinate (latched at each v_sync start)
//   pix_valid/x/y/rgb    recovered visible pixel, 1 clk after its strobe
//   locked               timing lock held
//   frame_count          locked frames completed (wraps)
//   probe_rgb/valid      colour captured at the probe coordinate
//   err_h, err_v         sticky line / frame length errors
//   frame_crc, crc_valid per-frame CRC and its 1-clk pulse
// -----------------------------------------------------------------------------
module vga_capture #(
   parameter int   H_VIS       = 640,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   V_VIS       = 480,
   parameter int   V_FP        = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 33,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_ce,
   input  logic        h_sync,
   input  logic        v_sync,
   input  logic [3:0]  red,
   input  logic [3:0]  green,
   input  logic [3:0]  blue,
   input  logic [15:0] probe_x,
   input  logic [15:0] probe_y,
   output logic        pix_valid,
   output logic [15:0] pix_x,
   output logic [15:0] pix_y,
   output logic [11:0] pix_rgb,
   output logic        locked,
   output logic [31:0] frame_count,
   output logic [11:0] probe_rgb,
   output logic        probe_valid,
   output logic        err_h,
   output logic        err_v,
   output logic [15:0] frame_crc,
   output logic        crc_valid
);

   localparam logic [15:0] H_TOT_M1 = 16'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [15:0] V_TOT_M1 = 16'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [15:0] H_ACT0   = 16'(H_SYNC + H_BP);
   localparam logic [15:0] H_ACT1   = 16'(H_SYNC + H_BP + H_VIS - 1);
   localparam logic [15:0] V_ACT0   = 16'(V_SYNC + V_BP);
   localparam logic [15:0] V_ACT1   = 16'(V_SYNC + V_BP + V_VIS - 1);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   state_t      state_q, state_d;
   logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
   logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic        pix_valid_q, pix_valid_d;
   logic [15:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [11:0] pix_rgb_q, pix_rgb_d;
   logic [31:0] frame_count_q, frame_count_d;
   logic [15:0] probe_x_lat_q, probe_x_lat_d, probe_y_lat_q, probe_y_lat_d;
   logic [11:0] probe_rgb_q, probe_rgb_d;
   logic        probe_valid_q, probe_valid_d;
   logic        err_h_q, err_h_d, err_v_q, err_v_d;

   // Strobe-level decode shared with the optional CRC block
   logic        h_start, v_start, line_bad, frame_bad, vis;
   logic [15:0] x_off, y_off;

   always_comb begin
      state_d       = state_q;
      hs_prev_d     = hs_prev_q;
      vs_prev_d     = vs_prev_q;
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      pix_valid_d   = 1'b0;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      pix_rgb_d     = pix_rgb_q;
      frame_count_d = frame_count_q;
      probe_x_lat_d = probe_x_lat_q;
      probe_y_lat_d = probe_y_lat_q;
      probe_rgb_d   = probe_rgb_q;
      probe_valid_d = probe_valid_q;
      err_h_d       = err_h_q;
      err_v_d       = err_v_q;
      h_start       = 1'b0;
      v_start       = 1'b0;
      line_bad      = 1'b0;
      frame_bad     = 1'b0;
      vis           = 1'b0;
      x_off         = '0;
      y_off         = '0;

      if (pix_ce) begin
         hs_prev_d = h_sync;
         vs_prev_d = v_sync;
         h_start   = (h_sync == SYNC_ACTIVE) && (hs_prev_q != SYNC_ACTIVE);
         v_start   = (v_sync == SYNC_ACTIVE) && (vs_prev_q != SYNC_ACTIVE);

         // Counts describe the pixel sampled on this strobe (sync start = 0)
         if (h_start)                 h_cnt_d = '0;
         else if (h_cnt_q != 16'hFFFF) h_cnt_d = h_cnt_q + 16'd1;
         if (v_start)                           v_cnt_d = '0;
         else if (h_start && v_cnt_q != 16'hFFFF) v_cnt_d = v_cnt_q + 16'd1;

         // Period just ended is count+1, so compare against total-1
         line_bad  = h_start && (h_cnt_q != H_TOT_M1);
         frame_bad = v_start && (v_cnt_q != V_TOT_M1);

         unique case (state_q)
            SEARCH:  if (v_start) state_d = MEASURE;
            MEASURE: begin
               if (line_bad)     state_d = SEARCH;
               else if (v_start) state_d = frame_bad ? SEARCH : LOCKED;
            end
            LOCKED: begin
               if (line_bad || frame_bad) begin
                  err_h_d = err_h_q | line_bad;
                  err_v_d = err_v_q | frame_bad;
                  state_d = SEARCH;
               end else if (v_start) begin
                  frame_count_d = frame_count_q + 32'd1;
               end
            end
            default: state_d = SEARCH;
         endcase

         if (v_start) begin
            probe_x_lat_d = probe_x;
            probe_y_lat_d = probe_y;
         end

         x_off = h_cnt_d - H_ACT0;
         y_off = v_cnt_d - V_ACT0;
         vis   = (state_q == LOCKED) && !line_bad && !frame_bad &&
                 (h_cnt_d >= H_ACT0) && (h_cnt_d <= H_ACT1) &&
                 (v_cnt_d >= V_ACT0) && (v_cnt_d <= V_ACT1);

         if (vis) begin
            pix_valid_d = 1'b1;
            pix_x_d     = x_off;
            pix_y_d     = y_off;
            pix_rgb_d   = {red, green, blue};
            if (x_off == probe_x_lat_q && y_off == probe_y_lat_q) begin
               probe_rgb_d   = {red, green, blue};
               probe_valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= SEARCH;
         hs_prev_q     <= ~SYNC_ACTIVE;
         vs_prev_q     <= ~SYNC_ACTIVE;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_rgb_q     <= '0;
         frame_count_q <= '0;
         probe_x_lat_q <= '0;
         probe_y_lat_q <= '0;
         probe_rgb_q   <= '0;
         probe_valid_q <= 1'b0;
         err_h_q       <= 1'b0;
         err_v_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         hs_prev_q     <= hs_prev_d;
         vs_prev_q     <= vs_prev_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         pix_valid_q   <= pix_valid_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_rgb_q     <= pix_rgb_d;
         frame_count_q <= frame_count_d;
         probe_x_lat_q <= probe_x_lat_d;
         probe_y_lat_q <= probe_y_lat_d;
         probe_rgb_q   <= probe_rgb_d;
         probe_valid_q <= probe_valid_d;
         err_h_q       <= err_h_d;
         err_v_q       <= err_v_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_rgb     = pix_rgb_q;
   assign locked      = (state_q == LOCKED);
   assign frame_count = frame_count_q;
   assign probe_rgb   = probe_rgb_q;
   assign probe_valid = probe_valid_q;
   assign err_h       = err_h_q;
   assign err_v       = err_v_q;

`ifdef VGA_CAPTURE_CRC_EN
   logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;
   logic        crc_valid_q, crc_valid_d;

   // CRC-16-CCITT, MSB first, one 16-bit word per call
   function automatic logic [15:0] crc16_word(input logic [15:0] c_in,
                                              input logic [15:0] d);
      logic [15:0] c;
      c = c_in;
      for (int i = 15; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   always_comb begin
      crc_d       = crc_q;
      frame_crc_d = frame_crc_q;
      crc_valid_d = 1'b0;
      if (pix_ce) begin
         if (v_start) begin
            // Publish only if the whole frame was seen locked and ends cleanly
            if (state_q == LOCKED && !line_bad && !frame_bad) begin
               frame_crc_d = crc_q;
               crc_valid_d = 1'b1;
            end
            crc_d = 16'hFFFF;
         end else if (state_q != LOCKED) begin
            crc_d = 16'hFFFF;
         end else if (vis) begin
            crc_d = crc16_word(crc_q, {4'b0000, red, green, blue});
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q       <= 16'hFFFF;
         frame_crc_q <= '0;
         crc_valid_q <= 1'b0;
      end else begin
         crc_q       <= crc_d;
         frame_crc_q <= frame_crc_d;
         crc_valid_q <= crc_valid_d;
      end
   end

   assign frame_crc = frame_crc_q;
   assign crc_valid = crc_valid_q;
`else
   assign frame_crc = '0;
   assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a reduced raster (15x11 totals,
// 8x6 visible) so many frames fit in a short run.
module tb_vga_capture;
   localparam int H_VIS = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
   localparam int V_VIS = 6, V_FP = 1, V_SYNC = 2, V_BP = 2;
   localparam int H_TOT = 15, V_TOT = 11, HA0 = 5, VA0 = 4;
   localparam logic [15:0] PX = 16'd3, PY = 16'd2;

   logic        clk = 1'b0, rst = 1'b1, pix_ce = 1'b0;
   logic        h_sync = 1'b1, v_sync = 1'b1;
   logic [3:0]  red = '0, green = '0, blue = '0;
   logic [15:0] probe_x = '0, probe_y = '0;
   logic        pix_valid, locked, probe_valid, err_h, err_v, crc_valid;
   logic [15:0] pix_x, pix_y, frame_crc;
   logic [11:0] pix_rgb, probe_rgb;
   logic [31:0] frame_count;

   vga_capture #(.H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
                 .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
                 .SYNC_ACTIVE(1'b0)) dut (
      .clk(clk), .rst(rst), .pix_ce(pix_ce), .h_sync(h_sync), .v_sync(v_sync),
      .red(red), .green(green), .blue(blue), .probe_x(probe_x), .probe_y(probe_y),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .locked(locked), .frame_count(frame_count), .probe_rgb(probe_rgb),
      .probe_valid(probe_valid), .err_h(err_h), .err_v(err_v),
      .frame_crc(frame_crc), .crc_valid(crc_valid));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stimulus-side bookkeeping (written only by the initial block)
   int   checks = 0, errors = 0;
   int   vstarts = 0, hs_cyc = 0, vs_cyc = 0;
   logic hs_drv_prev = 1'b1, vs_drv_prev = 1'b1;
   bit   zero_mode = 1'b0;

   // Monitor state (written only by the monitor)
   int          pv_tot = 0, bad_pv = 0, pv_tag = -1;
   logic [15:0] first_x = '0, first_y = '0, last_x = '0, last_y = '0;
   logic [11:0] first_rgb = '0, last_rgb = '0, pr_rgb = '0;
   logic        pr_v = 1'b0, lk_prev = 1'b0, eh_prev = 1'b0, ev_prev = 1'b0;
   int          rise_vs = -1, rise_dly = -1, errh_dly = -1, errv_dly = -1;
   logic        lk_at_errh = 1'b1, lk_at_errv = 1'b1;
   int          crc_n = 0;
   logic [15:0] crc_last = '0, crc_prev = '0;

   always @(negedge clk) begin
      if (pix_valid) begin
         pv_tot <= pv_tot + 1;
         if (!locked) bad_pv <= bad_pv + 1;
         if (pv_tag != vstarts) begin
            pv_tag    <= vstarts;
            first_x   <= pix_x;
            first_y   <= pix_y;
            first_rgb <= pix_rgb;
         end
         last_x   <= pix_x;
         last_y   <= pix_y;
         last_rgb <= pix_rgb;
         if (pix_x == PX && pix_y == PY) begin
            pr_v   <= probe_valid;
            pr_rgb <= probe_rgb;
         end
      end
      lk_prev <= locked;
      if (locked && !lk_prev) begin
         rise_vs  <= vstarts;
         rise_dly <= cyc - vs_cyc;
      end
      eh_prev <= err_h;
      if (err_h && !eh_prev) begin
         errh_dly   <= cyc - hs_cyc;
         lk_at_errh <= locked;
      end
      ev_prev <= err_v;
      if (err_v && !ev_prev) begin
         errv_dly   <= cyc - vs_cyc;
         lk_at_errv <= locked;
      end
      if (crc_valid) begin
         crc_n    <= crc_n + 1;
         crc_prev <= crc_last;
         crc_last <= frame_crc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One pixel: an idle clk, then a strobe clk carrying the inputs
   task automatic strobe(input logic hs, input logic vs, input logic [11:0] c);
      @(negedge clk);
      pix_ce = 1'b0;
      @(negedge clk);
      pix_ce = 1'b1;
      h_sync = hs;
      v_sync = vs;
      {red, green, blue} = c;
      if (!hs && hs_drv_prev) hs_cyc = cyc;
      if (!vs && vs_drv_prev) begin
         vs_cyc = cyc;
         vstarts++;
      end
      hs_drv_prev = hs;
      vs_drv_prev = vs;
   endtask

   task automatic send_line(input int vl, input int len);
      int x, y;
      logic [11:0] c;
      for (int h = 0; h < len; h++) begin
         c = 12'h000;
         if (!zero_mode && h >= HA0 && h < HA0 + H_VIS && vl >= VA0 && vl < VA0 + V_VIS) begin
            x = h - HA0;
            y = vl - VA0;
            c = {x[3:0], y[3:0], 4'hA};
            if (x == 3 && y == 2) c = 12'h5C3;
         end
         strobe(h >= H_SYNC, vl >= V_SYNC, c);
      end
   endtask

   task automatic send_frame(input int first, input int nl, input int bad_line, input int bad_len);
      for (int vl = first; vl < nl; vl++)
         send_line(vl, (vl == bad_line) ? bad_len : H_TOT);
   endtask

   task automatic settle();
      @(negedge clk);
      pix_ce = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [15:0] crc_ref_zero(input int words);
      logic [15:0] c;
      logic fb;
      c = 16'hFFFF;
      for (int w = 0; w < words; w++)
         for (int b = 0; b < 16; b++) begin
            fb = c[15];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
         end
      return c;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int n0;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_errs", {err_h, err_v, probe_valid, crc_valid}, 0);
      chk("rst_frame_crc", frame_crc, 0);
      probe_x = PX;
      probe_y = PY;
      rst = 1'b0;

      // Acquire lock
      send_frame(0, V_TOT, -1, 0); settle();
      chk("f1_not_locked", locked, 0);
      p0 = pv_tot;
      send_frame(0, V_TOT, -1, 0); settle();
      chk("f2_locked", locked, 1);
      chk("lock_rise_vstart", rise_vs, 2);
      chk("lock_rise_delay", rise_dly, 1);
      chk("f2_pixels", pv_tot - p0, 48);
      p0 = pv_tot;
      send_frame(0, V_TOT, -1, 0); settle();
      chk("f3_pixels", pv_tot - p0, 48);
      chk("first_xy", {first_x, first_y}, {16'd0, 16'd0});
      chk("first_rgb", first_rgb, 12'h00A);
      chk("last_xy", {last_x, last_y}, {16'd7, 16'd5});
      chk("last_rgb", last_rgb, 12'h75A);
      chk("f3_frame_count", frame_count, 1);
      chk("probe_valid_at_pix", pr_v, 1);
      chk("probe_rgb_at_pix", pr_rgb, 12'h5C3);
      chk("probe_rgb_hold", probe_rgb, 12'h5C3);

      // Short frame (10 lines) -> frame error at the next v_sync start
      send_frame(0, V_TOT - 1, -1, 0); settle();
      chk("f4_locked", locked, 1);
      chk("f4_err_v", err_v, 0);
      chk("f4_frame_count", frame_count, 2);
      send_frame(0, V_TOT, -1, 0); settle();
      chk("ferr_err_v", err_v, 1);
      chk("ferr_delay", errv_dly, 1);
      chk("ferr_locked_at", lk_at_errv, 0);
      chk("ferr_err_h", err_h, 0);
      chk("ferr_locked", locked, 0);
      send_frame(0, V_TOT, -1, 0); settle();
      chk("f6_measuring", locked, 0);

      // Relocks at frame 7 start; line 5 stretched to 16 pixels
      p0 = pv_tot;
      send_frame(0, V_TOT, 5, H_TOT + 1); settle();
      chk("lerr_pixels", pv_tot - p0, 16);
      chk("lerr_err_h", err_h, 1);
      chk("lerr_delay", errh_dly, 1);
      chk("lerr_locked_at", lk_at_errh, 0);
      chk("lerr_locked", locked, 0);
      send_frame(0, V_TOT, -1, 0); settle();
      chk("f8_measuring", locked, 0);
      send_frame(0, V_TOT, -1, 0); settle();
      chk("relock", locked, 1);
      chk("relock_err_h_sticky", err_h, 1);
      chk("relock_frame_count", frame_count, 2);

      // Reset part-way through a frame
      send_frame(0, 5, -1, 0); settle();
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_locked", locked, 0);
      chk("mrst_frame_count", frame_count, 0);
      chk("mrst_pix", {pix_valid, pix_x, pix_y}, 0);
      chk("mrst_rgb", {pix_rgb, probe_rgb}, 0);
      chk("mrst_flags", {err_h, err_v, probe_valid}, 0);
      rst = 1'b0;
      vstarts = 0;
      hs_drv_prev = 1'b1;
      vs_drv_prev = 1'b1;
      probe_x = 16'd9;   // outside the visible columns
      send_frame(5, V_TOT, -1, 0); settle();
      send_frame(0, V_TOT, -1, 0); settle();
      chk("mrst_f1_not_locked", locked, 0);
      send_frame(0, V_TOT, -1, 0); settle();
      chk("mrst_relock", locked, 1);
      chk("mrst_rise_vstart", rise_vs, 2);
      send_frame(0, V_TOT, -1, 0); settle();
      chk("probe_oor_invalid", probe_valid, 0);
      chk("mrst_frame_count", frame_count, 1);
      chk("no_pix_unlocked", bad_pv, 0);

`ifdef VGA_CAPTURE_CRC_EN
      zero_mode = 1'b1;
      send_frame(0, V_TOT, -1, 0); settle();
      n0 = crc_n;
      send_frame(0, V_TOT, -1, 0); settle();
      send_frame(0, V_TOT, -1, 0); settle();
      chk("crc_pulses", crc_n - n0, 2);
      chk("crc_value_a", crc_prev, crc_ref_zero(48));
      chk("crc_value_b", crc_last, crc_ref_zero(48));
`else
      n0 = 0;
      chk("crc_never_valid", crc_n, n0);
      chk("crc_tied_zero", frame_crc, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
